control_sequencer: RTL and testbench

- Microcoded control unit of the 8-bit bus CPU. It sits directly downstream of the instruction register and consumes its 4-bit opcode nibble.
- Runs a fetch/execute step counter and emits one control word per clock. The word drives every bus-attached block: PC, MAR, RAM, IR, A, B, ALU, flags, output register.
- It also handles conditional jumps from the flag inputs, early instruction termination, and a sticky halt.

---
 rtl/control_sequencer.sv | 125 ++++++++++++
 tb/tb_control_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control unit: fetch/execute step counter producing one 16-bit
// control word per clock, with conditional jumps, early termination and sticky halt.
module control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_LAST    = 4
) (
    input  logic                    i_CLOCK,
    input  logic                    i_CLEAR,
    input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
    input  logic                    i_FLAG_CARRY,
    input  logic                    i_FLAG_ZERO,
    output logic [15:0]             o_CONTROL,
    output logic [2:0]              o_STEP,
    output logic                    o_HALTED
);

    localparam logic [15:0] C_HLT      = 16'h0001;
    localparam logic [15:0] C_MAR_RB   = 16'h0002;
    localparam logic [15:0] C_RAM_RB   = 16'h0004;
    localparam logic [15:0] C_RAM_WB   = 16'h0008;
    localparam logic [15:0] C_IR_WB    = 16'h0010;
    localparam logic [15:0] C_IR_RB    = 16'h0020;
    localparam logic [15:0] C_A_RB     = 16'h0040;
    localparam logic [15:0] C_A_WB     = 16'h0080;
    localparam logic [15:0] C_ALU_WB   = 16'h0100;
    localparam logic [15:0] C_ALU_SUB  = 16'h0200;
    localparam logic [15:0] C_B_RB     = 16'h0400;
    localparam logic [15:0] C_OUT_RB   = 16'h0800;
    localparam logic [15:0] C_PC_INC   = 16'h1000;
    localparam logic [15:0] C_PC_WB    = 16'h2000;
    localparam logic [15:0] C_PC_LOAD  = 16'h4000;
    localparam logic [15:0] C_FLAGS_RB = 16'h8000;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(14);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(15);

    function automatic logic [15:0] ucode(input logic [2:0] step,
                                          input logic [OPCODE_WIDTH-1:0] op,
                                          input logic carry,
                                          input logic zero);
        logic [15:0] w;
        w = '0;
        if (step == 3'd0) begin
            w = C_PC_WB | C_MAR_RB;
        end else if (step == 3'd1) begin
            w = C_RAM_WB | C_IR_RB | C_PC_INC;
        end else begin
            case (op)
                OP_LDA: begin
                    if (step == 3'd2) w = C_IR_WB | C_MAR_RB;
                    else if (step == 3'd3) w = C_RAM_WB | C_A_RB;
                end
                OP_ADD, OP_SUB: begin
                    if (step == 3'd2) w = C_IR_WB | C_MAR_RB;
                    else if (step == 3'd3) w = C_RAM_WB | C_B_RB;
                    else if (step == 3'd4)
                        w = C_ALU_WB | C_A_RB | C_FLAGS_RB | ((op == OP_SUB) ? C_ALU_SUB : 16'h0000);
                end
                OP_STA: begin
                    if (step == 3'd2) w = C_IR_WB | C_MAR_RB;
                    else if (step == 3'd3) w = C_A_WB | C_RAM_RB;
                end
                OP_LDI: if (step == 3'd2) w = C_IR_WB | C_A_RB;
                OP_JMP: if (step == 3'd2) w = C_IR_WB | C_PC_LOAD;
                OP_JC:  if (step == 3'd2 && carry) w = C_IR_WB | C_PC_LOAD;
                OP_JZ:  if (step == 3'd2 && zero) w = C_IR_WB | C_PC_LOAD;
                OP_OUT: if (step == 3'd2) w = C_A_WB | C_OUT_RB;
                OP_HLT: if (step == 3'd2) w = C_HLT;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    logic [2:0]  step_q, step_d, step_plus;
    logic        halted_q, halted_d;
    logic [15:0] word_cur, word_nxt;

    assign step_plus = step_q + 3'd1;
    assign word_cur  = ucode(step_q, i_OPCODE, i_FLAG_CARRY, i_FLAG_ZERO);
    assign word_nxt  = ucode(step_plus, i_OPCODE, i_FLAG_CARRY, i_FLAG_ZERO);

    always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // An execute step whose successor word is empty ends the instruction early.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (step_q < 3'd2) begin
                step_d = step_plus;
            end else if (word_cur[0]) begin
                halted_d = 1'b1;
                step_d   = 3'd0;
            end else if (step_q == 3'(STEP_LAST) || word_nxt == 16'h0000) begin
                step_d = 3'd0;
            end else begin
                step_d = step_plus;
            end
        end
    end

    always_comb begin
        o_CONTROL = (i_CLEAR || halted_q) ? 16'h0000 : word_cur;
        o_STEP    = step_q;
        o_HALTED  = halted_q;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instructions, reset, halt
// and a random instruction stream against a per-opcode word-sequence model.
module tb_control_sequencer;

    localparam logic [15:0] HLT      = 16'h0001;
    localparam logic [15:0] MAR_RB   = 16'h0002;
    localparam logic [15:0] RAM_RB   = 16'h0004;
    localparam logic [15:0] RAM_WB   = 16'h0008;
    localparam logic [15:0] IR_WB    = 16'h0010;
    localparam logic [15:0] IR_RB    = 16'h0020;
    localparam logic [15:0] A_RB     = 16'h0040;
    localparam logic [15:0] A_WB     = 16'h0080;
    localparam logic [15:0] ALU_WB   = 16'h0100;
    localparam logic [15:0] ALU_SUB  = 16'h0200;
    localparam logic [15:0] B_RB     = 16'h0400;
    localparam logic [15:0] OUT_RB   = 16'h0800;
    localparam logic [15:0] PC_INC   = 16'h1000;
    localparam logic [15:0] PC_WB    = 16'h2000;
    localparam logic [15:0] PC_LOAD  = 16'h4000;
    localparam logic [15:0] FLAGS_RB = 16'h8000;
    localparam logic [15:0] WB_MASK  = RAM_WB | IR_WB | A_WB | ALU_WB | PC_WB;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  op;
    logic        fc, fz;
    logic [15:0] ctl;
    logic [2:0]  stp;
    logic        hlt;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] seq_q[$];

    always #5 clk = ~clk;

    control_sequencer #(.OPCODE_WIDTH(4), .STEP_LAST(4)) dut (
        .i_CLOCK(clk), .i_CLEAR(clr), .i_OPCODE(op),
        .i_FLAG_CARRY(fc), .i_FLAG_ZERO(fz),
        .o_CONTROL(ctl), .o_STEP(stp), .o_HALTED(hlt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-instruction word list: fetch pair followed by the execute words.
    function automatic void build_seq(input logic [3:0] o, input logic c, input logic z);
        seq_q = {};
        seq_q.push_back(PC_WB | MAR_RB);
        seq_q.push_back(RAM_WB | IR_RB | PC_INC);
        case (o)
            4'h1: begin seq_q.push_back(IR_WB | MAR_RB); seq_q.push_back(RAM_WB | A_RB); end
            4'h2, 4'h3: begin
                seq_q.push_back(IR_WB | MAR_RB);
                seq_q.push_back(RAM_WB | B_RB);
                seq_q.push_back(ALU_WB | A_RB | FLAGS_RB | ((o == 4'h3) ? ALU_SUB : 16'h0));
            end
            4'h4: begin seq_q.push_back(IR_WB | MAR_RB); seq_q.push_back(A_WB | RAM_RB); end
            4'h5: seq_q.push_back(IR_WB | A_RB);
            4'h6: seq_q.push_back(IR_WB | PC_LOAD);
            4'h7: seq_q.push_back(c ? (IR_WB | PC_LOAD) : 16'h0);
            4'h8: seq_q.push_back(z ? (IR_WB | PC_LOAD) : 16'h0);
            4'hE: seq_q.push_back(A_WB | OUT_RB);
            4'hF: seq_q.push_back(HLT);
            default: seq_q.push_back(16'h0);
        endcase
    endfunction

    // Entered 1 time unit after the edge that starts T0. abort_at >= 0 pulses
    // i_CLEAR during that step and returns with the sequencer back at T0.
    task automatic run_instr(input logic [3:0] o, input logic c, input logic z, input int abort_at);
        build_seq(o, c, z);
        for (int i = 0; i < seq_q.size(); i++) begin
            if (i < 2) begin
                op = 4'($urandom); fc = 1'($urandom); fz = 1'($urandom);
            end else if (i == 2) begin
                op = o; fc = c; fz = z;
            end else begin
                fc = 1'($urandom); fz = 1'($urandom);
            end
            #2;
            check($sformatf("op%h_T%0d_ctl", o, i), ctl, seq_q[i]);
            check($sformatf("op%h_T%0d_step", o, i), {13'd0, stp}, 16'(i));
            check($sformatf("op%h_T%0d_halted", o, i), {15'd0, hlt}, 16'd0);
            check($sformatf("op%h_T%0d_wb_count", o, i),
                  {15'd0, ($countones(ctl & WB_MASK) <= 1)}, 16'd1);
            if (i == abort_at) begin
                clr = 1'b1;
                #1;
                check("abort_ctl", ctl, 16'h0000);
                check("abort_step", {13'd0, stp}, 16'd0);
                clr = 1'b0;
                #1;
                check("abort_release_ctl", ctl, PC_WB | MAR_RB);
                check("abort_release_step", {13'd0, stp}, 16'd0);
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clr = 1'b1; op = 4'h0; fc = 1'b0; fz = 1'b0;
        #2;
        check("reset_ctl", ctl, 16'h0000);
        check("reset_step", {13'd0, stp}, 16'd0);
        check("reset_halted", {15'd0, hlt}, 16'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        run_instr(4'h2, 1'b0, 1'b0, 3);
        run_instr(4'h1, 1'b0, 1'b0, -1);
        run_instr(4'h2, 1'b1, 1'b0, -1);
        run_instr(4'h3, 1'b0, 1'b1, -1);
        run_instr(4'h4, 1'b0, 1'b0, -1);
        run_instr(4'h5, 1'b0, 1'b0, -1);
        run_instr(4'h6, 1'b0, 1'b0, -1);
        run_instr(4'h7, 1'b1, 1'b0, -1);
        run_instr(4'h7, 1'b0, 1'b1, -1);
        run_instr(4'h8, 1'b0, 1'b1, -1);
        run_instr(4'h8, 1'b1, 1'b0, -1);
        run_instr(4'hE, 1'b0, 1'b0, -1);
        run_instr(4'h0, 1'b1, 1'b1, -1);
        for (int u = 9; u <= 13; u++) run_instr(4'(u), 1'b1, 1'b1, -1);

        run_instr(4'hF, 1'b0, 1'b0, -1);
        for (int k = 0; k < 20; k++) begin
            op = 4'($urandom); fc = 1'($urandom); fz = 1'($urandom);
            #2;
            check("halt_flag", {15'd0, hlt}, 16'd1);
            check("halt_ctl", ctl, 16'h0000);
            check("halt_step", {13'd0, stp}, 16'd0);
            @(posedge clk);
            #1;
        end
        clr = 1'b1;
        #2;
        check("halt_clear_flag", {15'd0, hlt}, 16'd0);
        clr = 1'b0;
        run_instr(4'h5, 1'b0, 1'b0, -1);

        for (int n = 0; n < 1000; n++)
            run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), -1);

        #2;
        check("final_step", {13'd0, stp}, 16'd0);
        check("final_ctl", ctl, PC_WB | MAR_RB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
